// File: rtl/alpharetz_spi_arbiter.sv
// alpharetz_spi_arbiter: round-robin arbiter sharing one SPI controller among REQ_CNT requesters
// Ports: sys_clk/async_rst_n/sys_clk_en clocking; req_* requester side (valid/ready, packed payloads);
// rsp_* one-hot response pulse with shared data and timeout flag; start_txn/tx_data/p_addr/end_txn/rx_data
// controller handshake; busy and grant_id status.
module alpharetz_spi_arbiter #(
  parameter int REQ_CNT = 4,
  parameter int SPI_DATA_WIDTH = 8,
  parameter int P_ADDR_WIDTH = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int GW = $clog2(REQ_CNT),
  localparam int TW = $clog2(TIMEOUT_CYCLES)
) (
  input  logic                              sys_clk,
  input  logic                              async_rst_n,
  input  logic                              sys_clk_en,
  input  logic [REQ_CNT-1:0]                req_valid,
  output logic [REQ_CNT-1:0]                req_ready,
  input  logic [REQ_CNT*SPI_DATA_WIDTH-1:0] req_tx_data,
  input  logic [REQ_CNT*P_ADDR_WIDTH-1:0]   req_p_addr,
  output logic [REQ_CNT-1:0]                rsp_valid,
  output logic [SPI_DATA_WIDTH-1:0]         rsp_rx_data,
  output logic                              rsp_timeout,
  output logic                              start_txn,
  output logic [SPI_DATA_WIDTH-1:0]         tx_data,
  output logic [P_ADDR_WIDTH-1:0]           p_addr,
  input  logic                              end_txn,
  input  logic [SPI_DATA_WIDTH-1:0]         rx_data,
  output logic                              busy,
  output logic [GW-1:0]                     grant_id
);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3;
  localparam logic [REQ_CNT-1:0] ONE = REQ_CNT'(1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] G_LAST = GW'(REQ_CNT - 1);
  logic [1:0] state;
  logic [GW-1:0] rr_ptr, grant;
  logic found;
  logic [TW-1:0] timer;
  logic [SPI_DATA_WIDTH-1:0] tx_q, rx_q;
  logic [P_ADDR_WIDTH-1:0] addr_q;
  logic timeout_q;
  // Scan from farthest to nearest so the requester closest to rr_ptr is written last and wins.
  always_comb begin
    found = 1'b0;
    grant = '0;
    for (int k = REQ_CNT - 1; k >= 0; k--) begin
      if (req_valid[GW'((int'(rr_ptr) + k) % REQ_CNT)]) begin
        found = 1'b1;
        grant = GW'((int'(rr_ptr) + k) % REQ_CNT);
      end
    end
  end
  // Reset term keeps req_ready low while reset is held even though IDLE is the reset state.
  assign req_ready = (async_rst_n && sys_clk_en && state == IDLE && found) ? ONE << grant : '0;
  assign start_txn = state == ISSUE;
  assign busy = state != IDLE;
  assign rsp_valid = state == RESP ? ONE << grant_id : '0;
  assign rsp_rx_data = rx_q;
  assign rsp_timeout = timeout_q;
  assign tx_data = tx_q;
  assign p_addr = addr_q;
  always_ff @(posedge sys_clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state <= IDLE;
      rr_ptr <= '0;
      grant_id <= '0;
      timer <= '0;
      tx_q <= '0;
      rx_q <= '0;
      addr_q <= '0;
      timeout_q <= 1'b0;
    end else if (sys_clk_en) begin
      case (state)
        IDLE: if (found) begin
          tx_q <= req_tx_data[int'(grant)*SPI_DATA_WIDTH +: SPI_DATA_WIDTH];
          addr_q <= req_p_addr[int'(grant)*P_ADDR_WIDTH +: P_ADDR_WIDTH];
          grant_id <= grant;
          state <= ISSUE;
        end
        ISSUE: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: if (end_txn) begin
          rx_q <= rx_data;
          timeout_q <= 1'b0;
          state <= RESP;
        end else if (timer == T_LAST) begin
          rx_q <= '0;
          timeout_q <= 1'b1;
          state <= RESP;
        end else begin
          timer <= timer + 1'b1;
        end
        default: begin
          rr_ptr <= grant_id == G_LAST ? '0 : grant_id + 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alpharetz_spi_arbiter.sv
// tb_alpharetz_spi_arbiter: randomized self-checking bench with a round-robin reference model
module tb_alpharetz_spi_arbiter;
  localparam int TO = 24;
  logic sys_clk = 1'b0, async_rst_n = 1'b1, sys_clk_en = 1'b1, end_txn = 1'b0;
  logic [3:0] req_valid = '0, req_ready, rsp_valid;
  logic [31:0] req_tx_data = '0;
  logic [7:0] req_p_addr = '0, rx_data = '0, rsp_rx_data, tx_data;
  logic rsp_timeout, start_txn, busy;
  logic [1:0] p_addr, grant_id;
  int n_chk = 0, n_fail = 0, m_ptr = 0, start_raw = 0, rsp_raw = 0, ready_off_bad = 0;
  bit gate = 1'b0;
  logic [3:0] r_ready, r_rsp, r_after;
  logic [7:0] r_tx, r_rx;
  logic [1:0] r_addr, r_gid;
  logic r_to, r_first, r_done, r_stable;
  int r_starts, r_wait;

  alpharetz_spi_arbiter #(.REQ_CNT(4), .SPI_DATA_WIDTH(8), .P_ADDR_WIDTH(2), .TIMEOUT_CYCLES(TO)) dut (
    .sys_clk(sys_clk), .async_rst_n(async_rst_n), .sys_clk_en(sys_clk_en),
    .req_valid(req_valid), .req_ready(req_ready), .req_tx_data(req_tx_data), .req_p_addr(req_p_addr),
    .rsp_valid(rsp_valid), .rsp_rx_data(rsp_rx_data), .rsp_timeout(rsp_timeout),
    .start_txn(start_txn), .tx_data(tx_data), .p_addr(p_addr), .end_txn(end_txn), .rx_data(rx_data),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference: first valid requester at or after ptr, wrapping.
  function automatic int pick(input logic [3:0] v, input int ptr);
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (ptr + k) % 4;
      if (v[i[1:0]]) return i;
    end
    return -1;
  endfunction

  task automatic sample();
    if (start_txn) start_raw++;
    if (rsp_valid != 0) rsp_raw++;
    if (!sys_clk_en && req_ready !== 4'b0) ready_off_bad++;
  endtask

  // One enabled cycle; with gate set, a disabled cycle is inserted first.
  task automatic step();
    if (gate) begin
      sys_clk_en = 1'b0;
      @(posedge sys_clk);
      #1 sample();
      sys_clk_en = 1'b1;
    end
    @(posedge sys_clk);
    #1 sample();
  endtask

  // Runs one full transaction from IDLE; the controller answers after lat WAIT cycles if resp.
  task automatic txn(input logic [3:0] v, input logic [31:0] txa, input logic [7:0] aa,
                     input int lat, input bit resp, input logic [7:0] rxv, input bit hold);
    req_valid = v;
    req_tx_data = txa;
    req_p_addr = aa;
    #1 r_ready = req_ready;
    r_starts = 0; r_wait = 0; r_done = 1'b0; r_stable = 1'b1; r_rsp = '0; r_tx = 'x; r_addr = 'x;
    step();
    if (!hold) req_valid = '0;
    r_first = start_txn;
    for (int c = 0; c < 300 && !r_done; c++) begin
      end_txn = 1'b0;
      rx_data = ~rxv;
      if (start_txn) begin
        r_starts++;
        r_tx = tx_data;
        r_addr = p_addr;
      end else if (rsp_valid != 0) begin
        r_done = 1'b1;
        r_rsp = rsp_valid;
        r_rx = rsp_rx_data;
        r_to = rsp_timeout;
        r_gid = grant_id;
      end else if (busy) begin
        if (tx_data !== r_tx || p_addr !== r_addr) r_stable = 1'b0;
        if (resp && r_wait == lat) begin
          end_txn = 1'b1;
          rx_data = rxv;
        end
        r_wait++;
      end
      if (!r_done) step();
    end
    end_txn = 1'b0;
    step();
    r_after = rsp_valid;
    req_valid = hold ? v : '0;
  endtask

  task automatic test_reset();
    #2 async_rst_n = 1'b0;
    req_valid = 4'hF;
    repeat (2) @(posedge sys_clk);
    #1;
    n_chk++; if (req_ready !== 4'b0) begin n_fail++; $display("FAIL reset req_ready: got %b want 0000", req_ready); end
    n_chk++; if ({start_txn, busy, rsp_timeout} !== 3'b0) begin n_fail++; $display("FAIL reset start/busy/timeout: got %b want 000", {start_txn, busy, rsp_timeout}); end
    n_chk++; if (rsp_valid !== 4'b0) begin n_fail++; $display("FAIL reset rsp_valid: got %b want 0000", rsp_valid); end
    n_chk++; if ({grant_id, p_addr, tx_data, rsp_rx_data} !== 20'b0) begin n_fail++; $display("FAIL reset data outputs: got %h want 0", {grant_id, p_addr, tx_data, rsp_rx_data}); end
    req_valid = '0;
    #2 async_rst_n = 1'b1;
    m_ptr = 0;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_contention();
    for (int i = 0; i < 5; i++) begin
      int g;
      logic [3:0] e;
      logic [7:0] rxv;
      g = pick(4'hF, m_ptr);
      e = 4'b0001 << g;
      rxv = 8'($urandom);
      txn(4'hF, $urandom, 8'($urandom), $urandom_range(0, 5), 1'b1, rxv, 1'b1);
      n_chk++; if (g != i % 4) begin n_fail++; $display("FAIL contention model order %0d: got %0d want %0d", i, g, i % 4); end
      n_chk++; if (r_ready !== e) begin n_fail++; $display("FAIL contention ready %0d: got %b want %b", i, r_ready, e); end
      n_chk++; if (r_rsp !== e || r_rx !== rxv) begin n_fail++; $display("FAIL contention rsp %0d: got %b/%h want %b/%h", i, r_rsp, r_rx, e, rxv); end
      m_ptr = (g + 1) % 4;
    end
    req_valid = '0;
  endtask

  task automatic test_single();
    int g, s0;
    s0 = start_raw;
    g = pick(4'b0100, m_ptr);
    txn(4'b0100, 32'h00A5_0000, 8'h10, 20, 1'b1, 8'h3C, 1'b0);
    n_chk++; if (r_ready !== 4'b0100) begin n_fail++; $display("FAIL single ready: got %b want 0100", r_ready); end
    n_chk++; if (r_first !== 1'b1 || r_starts != 1 || start_raw - s0 != 1) begin n_fail++; $display("FAIL single start pulse: first=%b steps=%0d raw=%0d want 1/1/1", r_first, r_starts, start_raw - s0); end
    n_chk++; if (r_tx !== 8'hA5 || r_addr !== 2'd1) begin n_fail++; $display("FAIL single tx/addr: got %h/%0d want a5/1", r_tx, r_addr); end
    n_chk++; if (r_wait != 21 || !r_done) begin n_fail++; $display("FAIL single wait: got %0d done=%b want 21 done=1", r_wait, r_done); end
    n_chk++; if (r_rsp !== 4'b0100 || r_rx !== 8'h3C || r_to !== 1'b0) begin n_fail++; $display("FAIL single rsp: got %b/%h/%b want 0100/3c/0", r_rsp, r_rx, r_to); end
    n_chk++; if (r_gid !== 2'd2 || r_after !== 4'b0 || !r_stable) begin n_fail++; $display("FAIL single gid/after/stable: got %0d/%b/%b want 2/0000/1", r_gid, r_after, r_stable); end
    m_ptr = (g + 1) % 4;
    g = pick(4'b1001, m_ptr);
    txn(4'b1001, $urandom, 8'($urandom), 1, 1'b1, 8'h11, 1'b0);
    n_chk++; if (r_ready !== 4'b1000) begin n_fail++; $display("FAIL single rr_ptr probe: got %b want 1000", r_ready); end
    m_ptr = (g + 1) % 4;
  endtask

  task automatic test_wrap();
    int g;
    g = pick(4'b0100, m_ptr);
    txn(4'b0100, $urandom, 8'($urandom), 2, 1'b1, 8'h22, 1'b0);
    m_ptr = (g + 1) % 4;
    for (int i = 0; i < 2; i++) begin
      logic [3:0] e;
      g = pick(4'b0011, m_ptr);
      e = 4'b0001 << g;
      txn(4'b0011, $urandom, 8'($urandom), 3, 1'b1, 8'h33, 1'b1);
      n_chk++; if (r_ready !== e || e !== (4'b0001 << i)) begin n_fail++; $display("FAIL wrap grant %0d: got %b want %b", i, r_ready, 4'b0001 << i); end
      n_chk++; if (r_rsp !== e) begin n_fail++; $display("FAIL wrap rsp %0d: got %b want %b", i, r_rsp, e); end
      m_ptr = (g + 1) % 4;
    end
    req_valid = '0;
  endtask

  task automatic test_timeout();
    int g, rb, bc;
    g = pick(4'b0010, m_ptr);
    txn(4'b0010, $urandom, 8'($urandom), 0, 1'b0, 8'h00, 1'b0);
    n_chk++; if (r_wait != TO || !r_done) begin n_fail++; $display("FAIL timeout wait: got %0d done=%b want %0d", r_wait, r_done, TO); end
    n_chk++; if (r_rsp !== 4'b0010 || r_to !== 1'b1 || r_rx !== 8'h00) begin n_fail++; $display("FAIL timeout rsp: got %b/%b/%h want 0010/1/00", r_rsp, r_to, r_rx); end
    m_ptr = (g + 1) % 4;
    rb = rsp_raw; bc = 0;
    end_txn = 1'b1;
    rx_data = 8'hFF;
    repeat (3) begin step(); if (busy) bc++; end
    end_txn = 1'b0;
    n_chk++; if (rsp_raw != rb || bc != 0) begin n_fail++; $display("FAIL late end_txn: rsp=%0d busy=%0d want 0/0", rsp_raw - rb, bc); end
    g = pick(4'b0001, m_ptr);
    txn(4'b0001, $urandom, 8'($urandom), TO - 1, 1'b1, 8'h77, 1'b0);
    n_chk++; if (r_wait != TO || r_to !== 1'b0 || r_rx !== 8'h77) begin n_fail++; $display("FAIL coincide: wait=%0d to=%b rx=%h want %0d/0/77", r_wait, r_to, r_rx, TO); end
    m_ptr = (g + 1) % 4;
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic [3:0] v, e;
      logic [31:0] txa;
      logic [7:0] aa, rxv, erx;
      int g, lat, ew;
      bit resp, timed;
      v = 4'($urandom_range(1, 15));
      txa = $urandom;
      aa = 8'($urandom);
      rxv = 8'($urandom);
      lat = $urandom_range(0, TO + 2);
      resp = $urandom_range(0, 3) != 0;
      g = pick(v, m_ptr);
      e = 4'b0001 << g;
      timed = !resp || lat >= TO;
      ew = timed ? TO : lat + 1;
      erx = timed ? 8'h00 : rxv;
      txn(v, txa, aa, lat, resp, rxv, 1'b0);
      n_chk++; if (r_ready !== e) begin n_fail++; $display("FAIL rand ready %0d: got %b want %b", i, r_ready, e); end
      n_chk++; if (r_tx !== txa[g*8 +: 8] || r_addr !== aa[g*2 +: 2] || !r_stable) begin n_fail++; $display("FAIL rand payload %0d: got %h/%0d stable=%b want %h/%0d", i, r_tx, r_addr, r_stable, txa[g*8 +: 8], aa[g*2 +: 2]); end
      n_chk++; if (r_starts != 1 || r_wait != ew) begin n_fail++; $display("FAIL rand timing %0d: starts=%0d wait=%0d want 1/%0d", i, r_starts, r_wait, ew); end
      n_chk++; if (r_rsp !== e || r_rx !== erx || r_to !== timed || r_gid !== 2'(g)) begin n_fail++; $display("FAIL rand rsp %0d: got %b/%h/%b/%0d want %b/%h/%b/%0d", i, r_rsp, r_rx, r_to, r_gid, e, erx, timed, g); end
      n_chk++; if (r_after !== 4'b0) begin n_fail++; $display("FAIL rand rsp width %0d: got %b want 0000", i, r_after); end
      m_ptr = (g + 1) % 4;
    end
  endtask

  task automatic test_clk_en();
    int g;
    g = pick(4'b0010, m_ptr);
    gate = 1'b1;
    start_raw = 0; rsp_raw = 0; ready_off_bad = 0;
    txn(4'b0010, 32'h0000_C300, 8'h0C, 4, 1'b1, 8'h5A, 1'b0);
    gate = 1'b0;
    n_chk++; if (r_ready !== 4'b0010 || r_rsp !== 4'b0010 || r_rx !== 8'h5A) begin n_fail++; $display("FAIL clk_en grant/rsp: got %b/%b/%h want 0010/0010/5a", r_ready, r_rsp, r_rx); end
    n_chk++; if (r_starts != 1 || r_wait != 5 || r_tx !== 8'hC3 || r_addr !== 2'd3) begin n_fail++; $display("FAIL clk_en phases: starts=%0d wait=%0d tx=%h addr=%0d want 1/5/c3/3", r_starts, r_wait, r_tx, r_addr); end
    n_chk++; if (start_raw != 2 || rsp_raw != 2) begin n_fail++; $display("FAIL clk_en stretch: start=%0d rsp=%0d raw cycles want 2/2", start_raw, rsp_raw); end
    n_chk++; if (ready_off_bad != 0) begin n_fail++; $display("FAIL clk_en ready gating: %0d cycles with ready while disabled want 0", ready_off_bad); end
    m_ptr = (g + 1) % 4;
  endtask

  task automatic test_reset_wait();
    int rb, bc, g;
    req_valid = 4'b0100;
    req_tx_data = $urandom;
    req_p_addr = 8'($urandom);
    #1;
    step(); step(); step();
    n_chk++; if (busy !== 1'b1 || start_txn !== 1'b0) begin n_fail++; $display("FAIL rstwait in WAIT: busy=%b start=%b want 1/0", busy, start_txn); end
    #3 async_rst_n = 1'b0;
    #1;
    n_chk++; if ({start_txn, busy} !== 2'b0 || req_ready !== 4'b0) begin n_fail++; $display("FAIL rstwait immediate: start=%b busy=%b ready=%b want 0/0/0000", start_txn, busy, req_ready); end
    n_chk++; if (tx_data !== 8'h00 || p_addr !== 2'd0) begin n_fail++; $display("FAIL rstwait payload: got %h/%0d want 00/0", tx_data, p_addr); end
    req_valid = '0;
    #2 async_rst_n = 1'b1;
    m_ptr = 0;
    @(posedge sys_clk);
    #1;
    rb = rsp_raw; bc = 0;
    repeat (20) begin step(); if (busy) bc++; end
    n_chk++; if (rsp_raw != rb || bc != 0) begin n_fail++; $display("FAIL rstwait abandoned: rsp=%0d busy=%0d want 0/0", rsp_raw - rb, bc); end
    g = pick(4'hF, m_ptr);
    txn(4'hF, $urandom, 8'($urandom), 2, 1'b1, 8'h44, 1'b0);
    n_chk++; if (r_ready !== 4'b0001 || g != 0 || r_rsp !== 4'b0001) begin n_fail++; $display("FAIL rstwait next grant: got %b/%b want 0001/0001", r_ready, r_rsp); end
    m_ptr = (g + 1) % 4;
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_wrap();
    test_timeout();
    test_random();
    test_clk_en();
    test_reset_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
